// File: rtl/moving_window_filter_if.sv
// Sample/result bundle for the moving window filter: strobes, mode and sample in; result and valid out.
interface moving_window_filter_if #(
  parameter int WIDTH      = 4,
  parameter int LOG2_DEPTH = 2
);
  logic                        enable;
  logic                        clear;
  logic [1:0]                  mode;
  logic [WIDTH-1:0]            x;
  logic [WIDTH+LOG2_DEPTH-1:0] y;
  logic                        y_valid;

  modport master (output enable, clear, mode, x, input y, y_valid);
  modport slave  (input enable, clear, mode, x, output y, y_valid);
endinterface

// File: rtl/moving_window_filter.sv
// DEPTH-entry circular sample window with a registered pass/sum/average/delay output
// and a valid flag that waits for a full window in the windowed modes.
module moving_window_filter #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  moving_window_filter_if.slave  bus
);
  localparam int SW = WIDTH + LOG2_DEPTH;

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [WIDTH-1:0]        buf_reg [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr_reg;
  logic [LOG2_DEPTH-1:0]   fill_reg;
  logic [SW-1:0]           sum_reg;
  logic [SW-1:0]           sum_next;
  logic [SW-1:0]           y_reg, y_next;
  logic                    y_valid_reg, y_valid_next;
  logic                    accept;
  logic                    window_full;
  logic [WIDTH-1:0]        old_sample;
  logic [DEPTH-1:0]        we_vec;

  assign accept     = bus.enable & ~bus.clear;
  assign old_sample = buf_reg[wr_ptr_reg];
  // Running sum stays exact: the evicted sample is always part of the current sum.
  assign sum_next   = sum_reg + SW'(bus.x) - SW'(old_sample);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we_vec[gi] = accept && (wr_ptr_reg == LOG2_DEPTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) buf_reg[i] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) buf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we_vec[i]) buf_reg[i] <= bus.x;
    end
  end

  // Fill state machine: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FILLING;
    else        state_reg <= state_next;
  end

  // Fill state machine: next state
  always_comb begin
    state_next = state_reg;
    if (bus.clear)
      state_next = FILLING;
    else if (accept && state_reg == FILLING && fill_reg == LOG2_DEPTH'(DEPTH - 1))
      state_next = FULL;
  end

  // Fill state machine: outputs (valid as of the edge being evaluated)
  always_comb begin
    window_full = (state_next == FULL);
  end

  always_comb begin
    y_next       = y_reg;
    y_valid_next = y_valid_reg;
    if (accept) begin
      unique case (bus.mode)
        2'b00:   y_next = SW'(bus.x);
        2'b01:   y_next = sum_next;
        2'b10:   y_next = sum_next >> LOG2_DEPTH;
        default: y_next = SW'(old_sample);
      endcase
      y_valid_next = (bus.mode == 2'b00) ? 1'b1 : window_full;
    end
  end

  // fill_reg only counts while FILLING; its wrap coincides with the move to FULL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      fill_reg    <= '0;
      sum_reg     <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_reg  <= '0;
      fill_reg    <= '0;
      sum_reg     <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        sum_reg    <= sum_next;
        if (state_reg == FILLING) fill_reg <= fill_reg + 1'b1;
      end
      y_reg       <= y_next;
      y_valid_reg <= y_valid_next;
    end
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
endmodule

// File: tb/tb_moving_window_filter.sv
// Directed bench for moving_window_filter (WIDTH=4, DEPTH=4): vector table plus reset sequences.
module tb_moving_window_filter;
  logic clk;
  logic reset;

  moving_window_filter_if #(.WIDTH(4), .LOG2_DEPTH(2)) bus ();

  moving_window_filter #(.WIDTH(4), .DEPTH(4), .LOG2_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic [1:0] md;
    logic [3:0] x;
    logic [5:0] y;
    logic       yv;
  } vec_t;

  vec_t tbl[$];
  int   pass_count  = 0;
  int   total_count = 0;

  function automatic vec_t mk(input logic en, input logic clr, input logic [1:0] md,
                              input logic [3:0] x, input logic [5:0] y, input logic yv);
    vec_t v;
    v.en = en; v.clr = clr; v.md = md; v.x = x; v.y = y; v.yv = yv;
    return v;
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total_count++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      pass_count++;
  endtask

  task automatic drive(input logic en, input logic clr, input logic [1:0] md, input logic [3:0] xv);
    bus.enable = en;
    bus.clear  = clr;
    bus.mode   = md;
    bus.x      = xv;
  endtask

  initial begin
    // Sum fill 1..7
    tbl.push_back(mk(1, 1, 2'b01, 4'd5, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd1, 6'd1, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd2, 6'd3, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd3, 6'd6, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd4, 6'd10, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd5, 6'd14, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd6, 6'd18, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd7, 6'd22, 1));
    // Clear wins over enable, then enable gaps
    tbl.push_back(mk(1, 1, 2'b01, 4'd9, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd2, 6'd2, 0));
    tbl.push_back(mk(0, 0, 2'b01, 4'd2, 6'd2, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd2, 6'd4, 0));
    tbl.push_back(mk(0, 0, 2'b01, 4'd2, 6'd4, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd2, 6'd6, 0));
    tbl.push_back(mk(0, 0, 2'b01, 4'd2, 6'd6, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd2, 6'd8, 1));
    tbl.push_back(mk(0, 0, 2'b01, 4'd2, 6'd8, 1));
    // Average 1..7
    tbl.push_back(mk(0, 1, 2'b10, 4'd0, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'd1, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'd2, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'd3, 6'd1, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'd4, 6'd2, 1));
    tbl.push_back(mk(1, 0, 2'b10, 4'd5, 6'd3, 1));
    tbl.push_back(mk(1, 0, 2'b10, 4'd6, 6'd4, 1));
    tbl.push_back(mk(1, 0, 2'b10, 4'd7, 6'd5, 1));
    // Delay 1..9, pointer wraps twice
    tbl.push_back(mk(0, 1, 2'b11, 4'd0, 6'd0, 0));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(1, 0, 2'b11, 4'(i), (i > 4) ? 6'(i - 4) : 6'd0, (i >= 4) ? 1'b1 : 1'b0));
    // Maximum sum
    tbl.push_back(mk(0, 1, 2'b01, 4'd0, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd15, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd30, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd45, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd60, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd60, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd15, 6'd60, 1));
    // Mode change alone does not move y; window survives mode switches
    tbl.push_back(mk(0, 0, 2'b00, 4'd9, 6'd60, 1));
    tbl.push_back(mk(1, 0, 2'b00, 4'd3, 6'd3, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd0, 6'd33, 1));
    // Pass mode valid immediately, sum mode not valid while filling
    tbl.push_back(mk(0, 1, 2'b00, 4'd0, 6'd0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 4'd7, 6'd7, 1));
    tbl.push_back(mk(1, 0, 2'b01, 4'd1, 6'd8, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'd4, 6'd12, 0));

    reset = 1'b0;
    drive(1, 0, 2'b01, 4'd0);

    // Reset held low with activity on x
    for (int i = 0; i < 4; i++) begin
      bus.x = (i % 2 == 0) ? 4'hA : 4'h5;
      @(posedge clk); #1;
      $display("reset cycle %0d: y=%0d y_valid=%0b", i, bus.y, bus.y_valid);
      check("reset_y", bus.y, 6'd0);
      check("reset_valid", 6'(bus.y_valid), 6'd0);
    end
    reset = 1'b1;
    drive(0, 0, 2'b01, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("hold cycle %0d: y=%0d y_valid=%0b", i, bus.y, bus.y_valid);
      check("hold_y", bus.y, 6'd0);
      check("hold_valid", 6'(bus.y_valid), 6'd0);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].md, tbl[i].x);
      @(posedge clk); #1;
      $display("vec %0d: en=%0b clr=%0b mode=%0d x=%0d -> y=%0d y_valid=%0b (exp %0d/%0b)",
               i, tbl[i].en, tbl[i].clr, tbl[i].md, tbl[i].x, bus.y, bus.y_valid, tbl[i].y, tbl[i].yv);
      check($sformatf("vec%0d_y", i), bus.y, tbl[i].y);
      check($sformatf("vec%0d_valid", i), 6'(bus.y_valid), 6'(tbl[i].yv));
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    drive(1, 0, 2'b01, 4'd5);
    #2 reset = 1'b0;
    #1;
    $display("async reset: y=%0d y_valid=%0b", bus.y, bus.y_valid);
    check("async_reset_y", bus.y, 6'd0);
    check("async_reset_valid", 6'(bus.y_valid), 6'd0);
    @(posedge clk); #1;
    check("reset_held_y", bus.y, 6'd0);
    reset = 1'b1;
    // Restart from an empty window
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      $display("restart %0d: y=%0d y_valid=%0b", i, bus.y, bus.y_valid);
      check("restart_y", bus.y, 6'(5 * i));
      check("restart_valid", 6'(bus.y_valid), (i == 4) ? 6'd1 : 6'd0);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end
endmodule

// File: doc/moving_window_filter.md
Name: moving_window_filter

Overview:
Parametrised successor to the 4-bit enable/reset/clk x-to-y processing block. It accepts one WIDTH-bit sample per enabled clock into a DEPTH-entry circular buffer. It produces a registered output selected by mode: pass-through, moving sum, moving average, or DEPTH-sample delay. It sits in the same datapath position as its predecessor, with x in and y out, and adds window depth, mode select, synchronous clear and an output-valid flag.

Parameters:
WIDTH, 4, sample width in bits (>=1)
DEPTH, 4, window length in samples; power of two, >=2
LOG2_DEPTH, 2, log2(DEPTH); must match DEPTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  sample strobe; x accepted on rising clk while high
clear  input  1  synchronous flush; priority over enable
mode  input  2  00 pass, 01 sum, 10 average, 11 delay
x  input  WIDTH  input sample, unsigned
y  output  WIDTH+LOG2_DEPTH  registered result, unsigned
y_valid  output  1  y holds a full-window result (see below)

Behaviour:
- reset low (async, any time): buffer entries, wr_ptr, fill count, running sum, y and y_valid all go to 0 immediately. State stays 0 while reset is low.
- Priority per rising edge: reset > clear > enable > hold.
- clear=1: same zeroing as reset, synchronous; enable is ignored that cycle.
- enable=0, clear=0: all state and outputs hold. A change on mode alone does not update y.
- Accepted sample (enable=1, clear=0):
  - old = buf[wr_ptr]; buf[wr_ptr] <= x; wr_ptr <= wr_ptr+1, modulo DEPTH (natural wrap).
  - sum <= sum + x - old. The sum register is WIDTH+LOG2_DEPTH bits and can never overflow; max value is DEPTH*(2^WIDTH-1).
  - fill <= min(fill+1, DEPTH). Fill state machine: FILLING (fill<DEPTH) -> FULL when the DEPTH-th sample is accepted. FULL exits only on clear or reset.
- y, 1-cycle latency, updated only on accepted samples, using the mode sampled on that edge:
  - 00: y <= x, zero-extended.
  - 01: y <= new sum, which includes x.
  - 10: y <= new sum >> LOG2_DEPTH (floor), zero-extended.
  - 11: y <= old (the sample evicted this edge), zero-extended. This gives a delay of exactly DEPTH accepted samples; 0 during fill.
- y_valid, registered and updated on accepted samples:
  - mode 00: 1 from the first accepted sample.
  - other modes: 1 from the edge the window becomes FULL. During FILLING, y shows a partial sum or average over zero-initialised entries with y_valid=0.
  - A mode switch does not disturb buffer, sum or fill. y_valid on the next accepted sample follows the new mode's rule.
- Simultaneous clear and enable: clear wins and x is discarded.
- Reset released mid-stream: the block restarts in FILLING with an empty window.

Test Plan:
- Reset/hold: reset low with enable=1, x toggling -> y=0, y_valid=0 throughout. After release with enable=0 and x=4'hF for 5 cycles -> y stays 0.
- Sum fill (WIDTH=4, DEPTH=4, mode=01): x=1,2,3,4,5,6,7 on consecutive enabled edges -> y=1,3,6,10,14,18,22. y_valid=0,0,0,1,1,1,1.
- Average: same stimulus with mode=10 -> y=0,0,1,2,3,4,5. y_valid rises on the 4th sample.
- Delay and wrap: mode=11, x=1..9 -> y=0,0,0,0,1,2,3,4,5. This exercises wr_ptr wrapping twice.
- Saturation width: mode=01, x=15 for 6 samples -> y=15,30,45,60,60,60. No overflow in the 6-bit y.
- Clear and enable gaps: after the sum stream reaches 22, assert clear with enable=1 -> next edge gives y=0, y_valid=0. Then x=2 with enable pulsed every other cycle -> y=2,4,6,8 only on enabled edges, y_valid=1 at the 4th.
